ctrl_phase_sequencer: RTL and testbench

//  Parametrised top-level controller for the piped vector multiplier.

---
 rtl/ctrl_phase_sequencer.sv | 110 +++++++++++
 tb/tb_ctrl_phase_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ctrl_phase_sequencer.sv
// Phase sequencer for the piped vector multiplier: IDLE -> LOAD -> RUN -> DRAIN -> DONE.
// Optional CTRL_AUTO_RESTART_EN: a start seen in DONE goes straight back to LOAD.
module ctrl_phase_sequencer #(
  parameter int LOAD_CYCLES  = 8,
  parameter int RUN_CYCLES   = 8,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] step_count,
  output logic             load_en,
  output logic             run_en,
  output logic             busy,
  output logic             done,
  output logic             end_signal
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Last global step of each phase; the counter runs continuously across phases.
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(LOAD_CYCLES + RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LOAD_CYCLES + RUN_CYCLES + DRAIN_CYCLES - 1);

  state_t           st_q, st_n;
  logic [CNT_W-1:0] step_n;
  logic             end_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q       <= S_IDLE;
      step_count <= '0;
      end_signal <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      st_q       <= st_n;
      step_count <= step_n;
      end_signal <= end_n;
      busy       <= (st_n != S_IDLE);
      done       <= (st_n == S_DONE);
    end
  end

  always_comb begin
    st_n   = st_q;
    step_n = step_count;
    end_n  = end_signal;
    if (abort) begin
      st_n   = S_IDLE;
      step_n = '0;
      end_n  = 1'b0;
    end else begin
      case (st_q)
        S_IDLE: if (start) begin
          st_n   = S_LOAD;
          step_n = '0;
          end_n  = 1'b0;
        end
        S_LOAD: if (!hold) begin
          step_n = step_count + 1'b1;
          if (step_count == LOAD_LAST) st_n = S_RUN;
        end
        S_RUN: if (!hold) begin
          step_n = step_count + 1'b1;
          if (step_count == RUN_LAST) st_n = S_DRAIN;
        end
        S_DRAIN: if (!hold) begin
          if (step_count == DRAIN_LAST) begin
            st_n   = S_DONE;
            step_n = '1;   // completion sentinel, held until the next start
            end_n  = 1'b1;
          end else begin
            step_n = step_count + 1'b1;
          end
        end
        S_DONE: begin
`ifdef CTRL_AUTO_RESTART_EN
          if (start) begin
            st_n   = S_LOAD;
            step_n = '0;
            end_n  = 1'b0;
          end else begin
            st_n = S_IDLE;
          end
`else
          st_n = S_IDLE;
`endif
        end
        default: st_n = S_IDLE;
      endcase
    end
  end

  assign state   = st_q;
  assign load_en = (st_q == S_LOAD) && !hold;
  assign run_en  = (st_q == S_RUN) && !hold;

endmodule

// File: tb/tb_ctrl_phase_sequencer.sv
// Directed-vector bench for ctrl_phase_sequencer: default build plus a minimal-length instance.
module tb_ctrl_phase_sequencer;

  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, DRAIN = 3'd3, DONE = 3'd4;

  typedef struct {
    logic       start, hold, abort;
    logic [2:0] st;
    logic [4:0] step;
    logic       busy, done, endf;
  } vec_t;

  logic       clk = 1'b0, rstn = 1'b0;
  logic       start = 1'b0, hold = 1'b0, abort = 1'b0;
  logic [2:0] state;
  logic [4:0] step_count;
  logic       load_en, run_en, busy, done, end_signal;

  logic       s_start = 1'b0, s_hold = 1'b0, s_abort = 1'b0;
  logic [2:0] s_state, s_step;
  logic       s_load_en, s_run_en, s_busy, s_done, s_end;

  int nvec = 0, nfail = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  ctrl_phase_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start), .hold(hold), .abort(abort),
    .state(state), .step_count(step_count), .load_en(load_en), .run_en(run_en),
    .busy(busy), .done(done), .end_signal(end_signal));

  ctrl_phase_sequencer #(.LOAD_CYCLES(1), .RUN_CYCLES(1), .DRAIN_CYCLES(1), .CNT_W(3)) dut_s (
    .clk(clk), .rstn(rstn), .start(s_start), .hold(s_hold), .abort(s_abort),
    .state(s_state), .step_count(s_step), .load_en(s_load_en), .run_en(s_run_en),
    .busy(s_busy), .done(s_done), .end_signal(s_end));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, h, a, input logic [2:0] st, input logic [4:0] step,
                              input logic b, d, e);
    vec_t v;
    v.start = s; v.hold = h; v.abort = a; v.st = st; v.step = step;
    v.busy = b; v.done = d; v.endf = e;
    return v;
  endfunction

  function automatic logic [2:0] phase_of(input int i);
    return (i < 8) ? LOAD : (i < 16) ? RUN : DRAIN;
  endfunction

  task automatic push(input logic s, h, a, input logic [2:0] st, input logic [4:0] step,
                      input logic b, d, e);
    vq.push_back(mk(s, h, a, st, step, b, d, e));
  endtask

  task automatic add_steps(input int from, input int to, input logic s);
    for (int i = from; i <= to; i++) push(s, 1'b0, 1'b0, phase_of(i), 5'(i), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    start = v.start; hold = v.hold; abort = v.abort;
    @(posedge clk); #1;
    chk({tag, ".state"}, 32'(state), 32'(v.st));
    chk({tag, ".step"}, 32'(step_count), 32'(v.step));
    chk({tag, ".load_en"}, 32'(load_en), 32'(v.st == LOAD && !v.hold));
    chk({tag, ".run_en"}, 32'(run_en), 32'(v.st == RUN && !v.hold));
    chk({tag, ".busy"}, 32'(busy), 32'(v.busy));
    chk({tag, ".done"}, 32'(done), 32'(v.done));
    chk({tag, ".end"}, 32'(end_signal), 32'(v.endf));
  endtask

  initial begin
    // plain run, then hold in IDLE is harmless
    push(1,0,0, LOAD, 0, 1,0,0); add_steps(1, 18, 0);
    push(0,0,0, DONE, 31, 1,1,1); push(0,0,0, IDLE, 31, 0,0,1); push(0,1,0, IDLE, 31, 0,0,1);
    // hold: start accepted despite hold in IDLE, 3-cycle stall at step 10, hold in DONE ignored
    push(1,1,0, LOAD, 0, 1,0,0); add_steps(1, 10, 0);
    repeat (3) push(0,1,0, RUN, 10, 1,0,0);
    add_steps(11, 18, 0);
    push(0,0,0, DONE, 31, 1,1,1); push(0,1,0, IDLE, 31, 0,0,1);
    // abort clears sticky end in IDLE; abort mid-RUN beats start and hold
    push(0,0,1, IDLE, 0, 0,0,0);
    push(1,0,0, LOAD, 0, 1,0,0); add_steps(1, 12, 0);
    push(1,1,1, IDLE, 0, 0,0,0); push(0,0,0, IDLE, 0, 0,0,0);
    push(1,0,0, LOAD, 0, 1,0,0); add_steps(1, 18, 0);
    push(0,0,0, DONE, 31, 1,1,1); push(0,0,0, IDLE, 31, 0,0,1);
    // start held high throughout: ignored while busy, restart behaviour after DONE
    push(1,0,0, LOAD, 0, 1,0,0); add_steps(1, 18, 1);
    push(1,0,0, DONE, 31, 1,1,1);
`ifdef CTRL_AUTO_RESTART_EN
    push(1,0,0, LOAD, 0, 1,0,0); push(1,0,0, LOAD, 1, 1,0,0);
`else
    push(1,0,0, IDLE, 31, 0,0,1); push(1,0,0, LOAD, 0, 1,0,0);
`endif
    push(0,0,1, IDLE, 0, 0,0,0);

    #2;
    chk("rst.state", 32'(state), 0); chk("rst.step", 32'(step_count), 0);
    chk("rst.busy", 32'(busy), 0); chk("rst.done", 32'(done), 0);
    chk("rst.end", 32'(end_signal), 0); chk("rst.load_en", 32'(load_en), 0);
    #10 rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle.state", 32'(state), 0);

    for (int i = 0; i < vq.size(); i++) apply_vec(vq[i], $sformatf("v%0d", i));

    // asynchronous reset mid-LOAD at step 5
    apply_vec(mk(1,0,0, LOAD, 0, 1,0,0), "r0");
    for (int i = 1; i <= 5; i++) apply_vec(mk(0,0,0, LOAD, 5'(i), 1,0,0), $sformatf("r%0d", i));
    #3 rstn = 1'b0;
    #1;
    chk("async.state", 32'(state), 0); chk("async.step", 32'(step_count), 0);
    chk("async.busy", 32'(busy), 0); chk("async.load_en", 32'(load_en), 0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("inrst.state", 32'(state), 0); chk("inrst.step", 32'(step_count), 0);
    @(negedge clk); rstn = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("postrst.state", 32'(state), 0); chk("postrst.busy", 32'(busy), 0);

    // minimal phase lengths: steps 0,1,2 then DONE with 3-bit sentinel
    s_start = 1'b1;
    @(posedge clk); #1;
    chk("s0.state", 32'(s_state), 32'(LOAD)); chk("s0.step", 32'(s_step), 0);
    chk("s0.load_en", 32'(s_load_en), 1);
    s_start = 1'b0;
    @(posedge clk); #1;
    chk("s1.state", 32'(s_state), 32'(RUN)); chk("s1.step", 32'(s_step), 1);
    chk("s1.run_en", 32'(s_run_en), 1);
    @(posedge clk); #1;
    chk("s2.state", 32'(s_state), 32'(DRAIN)); chk("s2.step", 32'(s_step), 2);
    @(posedge clk); #1;
    chk("s3.state", 32'(s_state), 32'(DONE)); chk("s3.step", 32'(s_step), 7);
    chk("s3.done", 32'(s_done), 1); chk("s3.end", 32'(s_end), 1);
    @(posedge clk); #1;
    chk("s4.state", 32'(s_state), 32'(IDLE)); chk("s4.done", 32'(s_done), 0);
    chk("s4.busy", 32'(s_busy), 0); chk("s4.step", 32'(s_step), 7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
